// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Holds MAR/MDR, loads them from the shared datapath bus, and runs single
//   read/write transactions on a req/ack memory port with a bounded wait.
//
// Ports
//   Clk, Reset            clock (rising edge), asynchronous active-high reset
//   bus                   shared 16-bit datapath bus
//   LD_MAR, LD_MDR        load MAR / MDR from bus (IDLE only)
//   MEM_RD, MEM_WR        start read / write (IDLE only; read wins if both)
//   MAR, MDR              address and data registers (MDR feeds the bus mux)
//   busy, done, err       not-idle, one-cycle completion, sticky timeout flag
//   mem_addr, mem_wdata   mirror MAR / MDR
//   mem_req, mem_we       request (ACCESS only) and write enable
//   mem_ack, mem_rdata    memory completion and read data
//   state                 current FSM state (debug)
//
// Memory handshake: mem_req is held high for every ACCESS cycle. The memory
// completes by raising mem_ack for one cycle while mem_req is high; on a read
// mem_rdata must be valid in that cycle. mem_ack is ignored when mem_req is 0.
// If no ack arrives within TIMEOUT cycles (TIMEOUT != 0) the access aborts
// with err set; an ack in the final cycle still counts as completion.

module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] bus,
  input  logic        LD_MAR,
  input  logic        LD_MDR,
  input  logic        MEM_RD,
  input  logic        MEM_WR,
  output logic [15:0] MAR,
  output logic [15:0] MDR,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [1:0]  state
);

  // Counter only ever needs to reach TIMEOUT-1.
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          wr_q;
  logic [CW-1:0] cnt_q;
  logic          start;
  logic          timeout_hit;

  assign start       = (state_q == S_IDLE) && (MEM_RD || MEM_WR);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == LAST);

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_ACCESS;
      S_ACCESS: if (mem_ack || timeout_hit) state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath registers. Loads and start share the IDLE edge, so the access
  // that follows already sees the freshly loaded MAR/MDR.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      MAR   <= '0;
      MDR   <= '0;
      wr_q  <= 1'b0;
      cnt_q <= '0;
      err   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (LD_MAR) MAR <= bus;
          if (LD_MDR) MDR <= bus;
          if (start) begin
            wr_q  <= ~MEM_RD;  // read wins when both strobes are high
            cnt_q <= '0;
            err   <= 1'b0;
          end
        end
        S_ACCESS: begin
          if (mem_ack) begin
            if (!wr_q) MDR <= mem_rdata;
          end else if (timeout_hit) begin
            err <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Moore outputs: decoded from state and registers only.
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FINISH);
  assign mem_req   = (state_q == S_ACCESS);
  assign mem_we    = (state_q == S_ACCESS) && wr_q;
  assign mem_addr  = MAR;
  assign mem_wdata = MDR;
  assign state     = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
//   Directed cases followed by randomized transactions on mem_access_unit
//   (TIMEOUT = 4). A transaction-level model predicts MAR/MDR/err and the
//   number of request cycles from the wait length chosen for each access.

module tb_mem_access_unit;

  localparam int TO = 4;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] bus;
  logic        LD_MAR, LD_MDR, MEM_RD, MEM_WR;
  logic [15:0] MAR, MDR;
  logic        busy, done, err;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_req, mem_we;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [1:0]  state;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .Clk(Clk), .Reset(Reset), .bus(bus),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .MEM_RD(MEM_RD), .MEM_WR(MEM_WR),
    .MAR(MAR), .MDR(MDR), .busy(busy), .done(done), .err(err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .state(state)
  );

  // ---------------- clock ----------------
  always #5 Clk = ~Clk;

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_q[$];
  logic [15:0] m_mar, m_mdr;
  logic        m_err;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Step to just after the next rising edge; inputs are driven and outputs
  // sampled here, away from the edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_inputs();
    LD_MAR = 1'b0; LD_MDR = 1'b0; MEM_RD = 1'b0; MEM_WR = 1'b0;
    mem_ack = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_mar"},  MAR, 16'h0);
    check({tag, "_mdr"},  MDR, 16'h0);
    check({tag, "_busy"}, 16'(busy), 16'h0);
    check({tag, "_done"}, 16'(done), 16'h0);
    check({tag, "_err"},  16'(err), 16'h0);
    check({tag, "_req"},  16'(mem_req), 16'h0);
    check({tag, "_we"},   16'(mem_we), 16'h0);
  endtask

  // ---------------- driver tasks ----------------
  // One IDLE cycle of loads; a stray mem_ack here must have no effect.
  task automatic idle_load(input logic lmar, input logic lmdr, input logic [15:0] val);
    LD_MAR = lmar; LD_MDR = lmdr; bus = val;
    mem_ack = 1'($urandom_range(0, 1));
    tick();
    clear_inputs();
    bus = 16'($urandom);
    if (lmar) m_mar = val;
    if (lmdr) m_mdr = val;
    check("idle_busy", 16'(busy), 16'h0);
    check("idle_done", 16'(done), 16'h0);
    check("idle_mar", MAR, m_mar);
    check("idle_mdr", MDR, m_mdr);
    check("idle_err", 16'(err), 16'(m_err));
  endtask

  // Full transaction. wait_n = number of no-ack cycles before the ack;
  // wait_n >= TO means the memory never answers.
  task automatic access(input logic rd, input logic wr, input logic lmar, input logic lmdr,
                        input logic [15:0] val, input int wait_n,
                        input logic [15:0] rdata, input logic noise);
    logic acked;
    int   req_cycles;
    logic [15:0] exp_mdr;
    acked      = (wait_n < TO);
    req_cycles = acked ? wait_n + 1 : TO;
    if (lmar) m_mar = val;
    if (lmdr) m_mdr = val;
    exp_q.push_back((acked && rd) ? rdata : m_mdr);

    MEM_RD = rd; MEM_WR = wr; LD_MAR = lmar; LD_MDR = lmdr; bus = val;
    tick();
    clear_inputs();

    for (int n = 0; n < req_cycles; n++) begin
      check("acc_req",   16'(mem_req), 16'h1);
      check("acc_we",    16'(mem_we), 16'(!rd));
      check("acc_addr",  mem_addr, m_mar);
      check("acc_wdata", mem_wdata, m_mdr);
      check("acc_busy",  16'(busy), 16'h1);
      check("acc_done",  16'(done), 16'h0);
      check("acc_err",   16'(err), 16'h0);
      if (noise) begin
        LD_MAR = 1'b1; LD_MDR = 1'($urandom_range(0, 1)); bus = 16'hFFFF;
        MEM_WR = 1'b1; MEM_RD = 1'($urandom_range(0, 1));
      end
      mem_ack   = (n == wait_n);
      mem_rdata = (n == wait_n) ? rdata : 16'($urandom);
      tick();
    end
    mem_ack = 1'b0;

    m_err   = !acked;
    exp_mdr = exp_q.pop_front();
    check("fin_done", 16'(done), 16'h1);
    check("fin_req",  16'(mem_req), 16'h0);
    check("fin_busy", 16'(busy), 16'h1);
    check("fin_err",  16'(err), 16'(m_err));
    check("fin_mdr",  MDR, exp_mdr);
    check("fin_mar",  MAR, m_mar);
    m_mdr = exp_mdr;
    tick();
    clear_inputs();
    check("post_done", 16'(done), 16'h0);
    check("post_busy", 16'(busy), 16'h0);
    check("post_req",  16'(mem_req), 16'h0);
    check("post_err",  16'(err), 16'(m_err));
    check("post_mdr",  MDR, m_mdr);
    check("post_mar",  MAR, m_mar);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    clear_inputs();
    bus = 16'h0; mem_rdata = 16'h0;
    Reset = 1'b1;
    m_mar = 16'h0; m_mdr = 16'h0; m_err = 1'b0;
    repeat (2) tick();
    check_reset_values("rst");
    Reset = 1'b0;
    tick();

    // Reset in the middle of an access: outputs clear without a clock edge.
    idle_load(1'b1, 1'b1, 16'h2222);
    MEM_RD = 1'b1;
    tick();
    clear_inputs();
    tick();
    check("pre_rst_req", 16'(mem_req), 16'h1);
    #2 Reset = 1'b1;
    #1;
    check_reset_values("async_rst");
    #1 Reset = 1'b0;
    tick();
    m_mar = 16'h0; m_mdr = 16'h0; m_err = 1'b0;
    exp_q.delete();
    check("after_rst_done", 16'(done), 16'h0);
    idle_load(1'b1, 1'b0, 16'h0010);

    // Read, zero wait
    idle_load(1'b1, 1'b0, 16'h3000);
    access(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 0, 16'hBEEF, 1'b0);

    // Write with three wait cycles, MDR loaded together with MEM_WR
    idle_load(1'b1, 1'b0, 16'h4001);
    idle_load(1'b0, 1'b1, 16'h5555);
    access(1'b0, 1'b1, 1'b0, 1'b1, 16'h1234, 3, 16'h7777, 1'b0);

    // Timeout with no ack, then the next read clears err
    access(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, TO + 5, 16'hDEAD, 1'b0);
    access(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1, 16'h1357, 1'b0);

    // Ack on the final allowed cycle wins
    access(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, TO - 1, 16'h0A0A, 1'b0);

    // Strobes while busy are dropped; both strobes at start means read
    access(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 2, 16'h9999, 1'b1);
    access(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1, 16'h2468, 1'b1);

    // Randomized transactions
    for (int i = 0; i < 60; i++) begin
      logic rd, wr;
      if ($urandom_range(0, 2) == 0)
        idle_load(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
      rd = 1'($urandom_range(0, 1));
      wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      access(rd, wr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
             int'($urandom_range(0, TO + 2)), 16'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
